// File: rtl/mips_pkg.sv
// Shared Mips core definitions used by the issue-stage hazard scoreboard.
// Holds the scoreboard slot record, the register-file forward select value
// and the standard result latencies. No ports.
package mips_pkg;

    // Record widths; scoreboard REG_AW/LAT_W must not exceed these.
    localparam int unsigned SB_REG_AW = 5;
    localparam int unsigned SB_LAT_W  = 2;

    // Forward select meaning "read the register file".
    localparam int unsigned FWD_RF = 0;

    // Slots before a result can be forwarded.
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    // One in-flight producer tracked by the scoreboard.
    typedef struct packed {
        logic                 valid;
        logic [SB_REG_AW-1:0] dest;
        logic [SB_LAT_W-1:0]  lat;
    } sb_slot_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/Execute side bundle of the issue scoreboard.
// master: Decode/Execute driver (id_* request, ex_if_stall), sees the decision.
// slave : scoreboard, returns is_stall, id_issue, fwd_sel, busy, stall_cnt.
interface issue_scoreboard_if #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned LAT_W      = 2,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned FWD_W = $clog2(PIPE_DEPTH + 1);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dest_addr;
    logic                      id_writereg;
    logic [LAT_W-1:0]          id_lat;
    logic                      ex_if_stall;
    logic                      is_stall;
    logic                      id_issue;
    logic [NUM_SRC*FWD_W-1:0]  fwd_sel;
    logic                      busy;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_dest_addr, id_writereg, id_lat, ex_if_stall,
        input  is_stall, id_issue, fwd_sel, busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_dest_addr, id_writereg, id_lat, ex_if_stall,
        output is_stall, id_issue, fwd_sel, busy, stall_cnt
    );

endinterface

// File: rtl/sb_src_match.sv
// Priority match of one source register against all scoreboard slots.
// Inputs : src_addr, src_used, slots (slot 0 = youngest).
// Outputs: stall (source must wait), fwd_sel (0 = register file, n = slot n-1).
// ISSUE_SB_FWD_EN: when undefined, any match before WB stalls and fwd_sel = 0.
module sb_src_match
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW     = SB_REG_AW,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned FWD_W      = 2
) (
    input  logic [REG_AW-1:0]             src_addr,
    input  logic                          src_used,
    input  sb_slot_t [PIPE_DEPTH-1:0]     slots,
    output logic                          stall,
    output logic [FWD_W-1:0]              fwd_sel
);

    logic        hit;
    int unsigned hit_idx;
`ifdef ISSUE_SB_FWD_EN
    logic [SB_LAT_W-1:0] hit_lat;
`endif

    // Scan oldest to youngest so the youngest producer overrides.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
`ifdef ISSUE_SB_FWD_EN
        hit_lat = '0;
`endif
        for (int s = int'(PIPE_DEPTH) - 1; s >= 0; s--) begin
            if (src_used && (src_addr != '0) && slots[s].valid &&
                (slots[s].dest == SB_REG_AW'(src_addr))) begin
                hit     = 1'b1;
                hit_idx = unsigned'(s);
`ifdef ISSUE_SB_FWD_EN
                hit_lat = slots[s].lat;
`endif
            end
        end
    end

    // The WB slot is covered by register-file write-through.
    always_comb begin
        stall   = 1'b0;
        fwd_sel = FWD_W'(FWD_RF);
        if (hit && (hit_idx < PIPE_DEPTH - 1)) begin
`ifdef ISSUE_SB_FWD_EN
            if (hit_idx + 1 < 32'(hit_lat)) begin
                stall = 1'b1;
            end else begin
                fwd_sel = FWD_W'(hit_idx + 1);
            end
`else
            stall = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard between Decode and Execute.
// Ports: clock, reset (async active-low), sb (issue_scoreboard_if.slave):
//   id_* decoded instruction, ex_if_stall freeze; is_stall, id_issue, fwd_sel,
//   busy (combinational), stall_cnt (registered, saturating).
// ISSUE_SB_FWD_EN: enables operand forwarding; undefined = stall until WB.
module issue_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW     = SB_REG_AW,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned LAT_W      = SB_LAT_W,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    issue_scoreboard_if.slave sb
);

    localparam int unsigned FWD_W = $clog2(PIPE_DEPTH + 1);

    sb_slot_t [PIPE_DEPTH-1:0] slots;
    sb_slot_t                  new_slot;
    logic [LAT_W-1:0]          lat_clamp;
    logic [NUM_SRC-1:0]        src_stall;
    logic [NUM_SRC*FWD_W-1:0]  fwd_vec;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic                      any_valid;
    logic                      is_stall_c;
    logic                      id_issue_c;

    // Per-source hazard and forward resolution.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        sb_src_match #(
            .REG_AW     (REG_AW),
            .PIPE_DEPTH (PIPE_DEPTH),
            .FWD_W      (FWD_W)
        ) u_match (
            .src_addr (sb.id_src_addr[k*REG_AW +: REG_AW]),
            .src_used (sb.id_src_used[k]),
            .slots    (slots),
            .stall    (src_stall[k]),
            .fwd_sel  (fwd_vec[k*FWD_W +: FWD_W])
        );
    end

    assign is_stall_c = sb.id_valid & (|src_stall);
    assign id_issue_c = sb.id_valid & ~is_stall_c & ~sb.ex_if_stall;

    // Latency clamped into 1..PIPE_DEPTH-1.
    always_comb begin
        lat_clamp = sb.id_lat;
        if (sb.id_lat == '0) begin
            lat_clamp = LAT_W'(1);
        end else if (32'(sb.id_lat) > PIPE_DEPTH - 1) begin
            lat_clamp = LAT_W'(PIPE_DEPTH - 1);
        end
    end

    // Entry entering EX; r0 and non-issued cycles become bubbles.
    always_comb begin
        new_slot = '0;
        if (id_issue_c && sb.id_writereg && (sb.id_dest_addr != '0)) begin
            new_slot.valid = 1'b1;
            new_slot.dest  = SB_REG_AW'(sb.id_dest_addr);
            new_slot.lat   = SB_LAT_W'(lat_clamp);
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
            any_valid = any_valid | slots[s].valid;
        end
    end

    // Slot pipeline and hazard-stall counter; both freeze while Execute is busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slots       <= '0;
            stall_cnt_q <= '0;
        end else if (!sb.ex_if_stall) begin
            slots <= {slots[PIPE_DEPTH-2:0], new_slot};
            if (is_stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sb.is_stall  = is_stall_c;
    assign sb.id_issue  = id_issue_c;
    assign sb.fwd_sel   = fwd_vec;
    assign sb.busy      = any_valid;
    assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: stimulus pushes expectations into a
// queue, a monitor pops and compares at the falling edge.
// Expectations follow the build: ISSUE_SB_FWD_EN defined or not.
module tb_issue_scoreboard;
    import mips_pkg::*;

    typedef struct {
        string       name;
        logic        stall;
        logic        issue;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic chk_en;
    logic [15:0] e_cnt;
    exp_t exp_q[$];
    event chk_now;

    issue_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .PIPE_DEPTH(3), .LAT_W(2), .CNT_W(16)) sb_if ();

    issue_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL no_expect: output sampled with empty expectation queue");
            return;
        end
        e = exp_q.pop_front();
        cmp(e.name, "is_stall",  32'(sb_if.is_stall),      32'(e.stall));
        cmp(e.name, "id_issue",  32'(sb_if.id_issue),      32'(e.issue));
        cmp(e.name, "fwd_sel0",  32'(sb_if.fwd_sel[1:0]),  32'(e.f0));
        cmp(e.name, "fwd_sel1",  32'(sb_if.fwd_sel[3:2]),  32'(e.f1));
        cmp(e.name, "busy",      32'(sb_if.busy),          32'(e.busy));
        cmp(e.name, "stall_cnt", 32'(sb_if.stall_cnt),     32'(e.cnt));
    endtask

    always @(negedge clock) if (chk_en) check_one();
    always @(chk_now) check_one();

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] dest, input logic wr, input logic [1:0] lat, input logic exs);
        sb_if.id_valid     = v;
        sb_if.id_src_addr  = {s1, s0};
        sb_if.id_src_used  = used;
        sb_if.id_dest_addr = dest;
        sb_if.id_writereg  = wr;
        sb_if.id_lat       = lat;
        sb_if.ex_if_stall  = exs;
    endtask

    task automatic push(input string nm, input logic v, input logic exs, input logic st,
                        input logic [1:0] f0, input logic [1:0] f1, input logic bz);
        exp_t e;
        e.name  = nm;
        e.stall = st;
        e.issue = v & ~st & ~exs;
        e.f0    = f0;
        e.f1    = f1;
        e.busy  = bz;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
    endtask

    // One cycle: drive after the rising edge, expectation checked at the falling edge.
    task automatic step(input string nm, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] dest, input logic wr, input logic [1:0] lat,
                        input logic exs, input logic st, input logic [1:0] f0, input logic [1:0] f1,
                        input logic bz, input bit chk = 1'b1);
        @(posedge clock);
        #1;
        drive(v, s0, s1, used, dest, wr, lat, exs);
        if (chk) push(nm, v, exs, st, f0, f1, bz);
        chk_en = chk;
        if (st && !exs && (e_cnt != 16'hffff)) e_cnt = e_cnt + 16'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        e_cnt  = 16'd0;
        reset  = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0);

        // Reset state: empty scoreboard, issue follows valid and ex_if_stall only.
        step("rst_exs", 1, 3, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0);
        #2 reset = 1'b1;
        step("rst_rel", 1, 3, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0);

        // ALU producer then dependent.
        step("alu_prod", 1, 0, 0, 2'b00, 3, 1, LAT_ALU[1:0], 0, 0, 0, 0, 0);
`ifdef ISSUE_SB_FWD_EN
        step("alu_dep", 1, 3, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 1);
`else
        step("alu_dep_s0", 1, 3, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
        step("alu_dep_s1", 1, 3, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
        step("alu_dep_wb", 1, 3, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 1);
`endif
        idle(3);
        step("empty_alu", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);

        // Load-use on source 1.
        step("ld_prod", 1, 0, 0, 2'b00, 5, 1, LAT_LOAD[1:0], 0, 0, 0, 0, 0);
`ifdef ISSUE_SB_FWD_EN
        step("ld_use_stall", 1, 0, 5, 2'b10, 0, 0, 1, 0, 1, 0, 0, 1);
        step("ld_use_fwd",   1, 0, 5, 2'b10, 0, 0, 1, 0, 0, 0, 2, 1);
`else
        step("ld_use_s0", 1, 0, 5, 2'b10, 0, 0, 1, 0, 1, 0, 0, 1);
        step("ld_use_s1", 1, 0, 5, 2'b10, 0, 0, 1, 0, 1, 0, 0, 1);
        step("ld_use_wb", 1, 0, 5, 2'b10, 0, 0, 1, 0, 0, 0, 0, 1);
`endif
        idle(3);
        step("empty_ld", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);

        // Youngest producer wins.
        step("y_old", 1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0, 0, 0);
        step("y_new", 1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0, 0, 1);
`ifdef ISSUE_SB_FWD_EN
        step("y_pick", 1, 4, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 1);
`else
        step("y_s0", 1, 4, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
        step("y_s1", 1, 4, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
        step("y_wb", 1, 4, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 1);
`endif
        idle(3);

        // r0 is never recorded; unused sources never stall.
        step("r0_prod", 1, 0, 0, 2'b00, 0, 1, 2, 0, 0, 0, 0, 0);
        step("r0_use",  1, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
        step("u_prod",  1, 0, 0, 2'b00, 6, 1, 2, 0, 0, 0, 0, 0);
        step("u_unused", 1, 6, 6, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1);
`ifdef ISSUE_SB_FWD_EN
        step("u_fwd", 1, 0, 6, 2'b10, 0, 0, 1, 0, 0, 0, 2, 1);
`else
        step("u_s1", 1, 0, 6, 2'b10, 0, 0, 1, 0, 1, 0, 0, 1);
        step("u_wb", 1, 0, 6, 2'b10, 0, 0, 1, 0, 0, 0, 0, 1);
`endif
        idle(3);

        // Pending load frozen by ex_if_stall for three cycles.
        step("fz_prod",  1, 0, 0, 2'b00, 7, 1, 2, 0, 0, 0, 0, 0);
        step("fz_hold0", 1, 7, 0, 2'b01, 0, 0, 1, 1, 1, 0, 0, 1);
        step("fz_hold1", 1, 7, 0, 2'b01, 0, 0, 1, 1, 1, 0, 0, 1);
        step("fz_hold2", 1, 7, 0, 2'b01, 0, 0, 1, 1, 1, 0, 0, 1);
        step("fz_rel",   1, 7, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
`ifdef ISSUE_SB_FWD_EN
        step("fz_fwd", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 2, 0, 1);
`else
        step("fz_s1", 1, 7, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 1);
        step("fz_wb", 1, 7, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 1);
`endif
        idle(3);

        // Fill all three slots, then drop reset between edges.
        step("mf_a",    1, 0, 0, 2'b00, 8,  1, 1, 0, 0, 0, 0, 0);
        step("mf_b",    1, 0, 0, 2'b00, 9,  1, 1, 0, 0, 0, 0, 1);
        step("mf_c",    1, 0, 0, 2'b00, 10, 1, 1, 0, 0, 0, 0, 1);
        step("mf_full", 0, 0, 0, 2'b00, 0,  0, 1, 0, 0, 0, 0, 1);
        @(negedge clock);
        #1;
        chk_en = 1'b0;
        drive(1, 10, 9, 2'b11, 0, 0, 1, 0);
        reset = 1'b0;
        e_cnt = 16'd0;
        #1;
        push("mf_reset", 1, 0, 0, 0, 0, 0);
        -> chk_now;
        #1 reset = 1'b1;
        step("mf_after", 1, 10, 9, 2'b11, 0, 0, 1, 0, 0, 0, 0, 0);

        @(posedge clock);
        #1;
        chk_en = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
